gmii_tx_arbiter: RTL and testbench

GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

---
 rtl/gmii_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_gmii_tx_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_arbiter.sv
// Two-requester round-robin arbiter and GMII byte framer: preamble, SFD, payload, inter-frame gap.
// Define GMII_TX_PAD_EN to build the PAD state that zero-fills short frames up to 60 payload bytes.
module gmii_tx_arbiter #(
   parameter int IFG_BYTES = 12,
   parameter int PRE_BYTES = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       byte_stb,
   input  logic [1:0] req,
   output logic [1:0] grant,
   input  logic [7:0] s_data0,
   input  logic [7:0] s_data1,
   input  logic [1:0] s_valid,
   input  logic [1:0] s_last,
   output logic [1:0] s_ready,
   output logic [7:0] tx_data,
   output logic       tx_en,
   output logic       tx_er,
   output logic       busy
);
   localparam logic [7:0] PRE_LAST = 8'(PRE_BYTES - 1);
   localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);
`ifdef GMII_TX_PAD_EN
   localparam logic [7:0] MIN_BYTES = 8'd60;
`endif

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      SFD,
      DATA,
`ifdef GMII_TX_PAD_EN
      PAD,
`endif
      IFG
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt, cnt_inc;
   logic       rr, rr_nxt;
   logic [1:0] grant_nxt;
   logic [7:0] tx_data_nxt;
   logic       tx_en_nxt, tx_er_nxt;
   logic       sel, sel_valid, sel_last;
   logic [7:0] sel_data;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign sel       = grant[1];
   assign sel_valid = sel ? s_valid[1] : s_valid[0];
   assign sel_last  = sel ? s_last[1]  : s_last[0];
   assign sel_data  = sel ? s_data1    : s_data0;
   assign cnt_inc   = sat_inc(cnt);
   assign busy      = (state != IDLE);
   // Consumption handshake is combinational so the source sees it on the strobe it is taken.
   assign s_ready   = (state == DATA && byte_stb) ? (grant & s_valid) : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         rr      <= 1'b0;
         grant   <= 2'b00;
         tx_data <= 8'h00;
         tx_en   <= 1'b0;
         tx_er   <= 1'b0;
      end else if (byte_stb) begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rr      <= rr_nxt;
         grant   <= grant_nxt;
         tx_data <= tx_data_nxt;
         tx_en   <= tx_en_nxt;
         tx_er   <= tx_er_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rr_nxt      = rr;
      grant_nxt   = grant;
      tx_data_nxt = 8'h00;
      tx_en_nxt   = 1'b0;
      tx_er_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            // rr names the requester that wins a tie; the granting strobe already emits preamble byte 1.
            if (req != 2'b00) begin
               if (req == 2'b11) grant_nxt = rr ? 2'b10 : 2'b01;
               else              grant_nxt = req;
               rr_nxt      = ~grant_nxt[1];
               tx_data_nxt = 8'h55;
               tx_en_nxt   = 1'b1;
               cnt_nxt     = 8'd1;
               state_nxt   = (PRE_BYTES > 1) ? PRE : SFD;
            end
         end
         PRE: begin
            tx_data_nxt = 8'h55;
            tx_en_nxt   = 1'b1;
            cnt_nxt     = cnt + 8'd1;
            if (cnt >= PRE_LAST) state_nxt = SFD;
         end
         SFD: begin
            tx_data_nxt = 8'hD5;
            tx_en_nxt   = 1'b1;
            cnt_nxt     = 8'd0;
            state_nxt   = DATA;
         end
         DATA: begin
            if (sel_valid) begin
               tx_data_nxt = sel_data;
               tx_en_nxt   = 1'b1;
               cnt_nxt     = cnt_inc;
               if (sel_last) begin
                  grant_nxt = 2'b00;
`ifdef GMII_TX_PAD_EN
                  if (cnt_inc < MIN_BYTES) begin
                     state_nxt = PAD;
                  end else begin
                     state_nxt = IFG;
                     cnt_nxt   = 8'd0;
                  end
`else
                  state_nxt = IFG;
                  cnt_nxt   = 8'd0;
`endif
               end
            end else begin
               tx_en_nxt = 1'b1;
               tx_er_nxt = 1'b1;
               grant_nxt = 2'b00;
               cnt_nxt   = 8'd0;
               state_nxt = IFG;
            end
         end
`ifdef GMII_TX_PAD_EN
         PAD: begin
            tx_en_nxt = 1'b1;
            cnt_nxt   = cnt_inc;
            if (cnt_inc >= MIN_BYTES) begin
               state_nxt = IFG;
               cnt_nxt   = 8'd0;
            end
         end
`endif
         IFG: begin
            if (cnt >= IFG_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Bench for gmii_tx_arbiter: directed and random frames checked slot by slot against a frame-level model.
`timescale 1ns/1ps
module tb_gmii_tx_arbiter;
   localparam int IFG = 12;
   localparam int PRE = 7;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       byte_stb = 1'b0;
   logic [1:0] req = 2'b00;
   logic [1:0] grant;
   logic [7:0] s_data0 = 8'h00;
   logic [7:0] s_data1 = 8'h00;
   logic [1:0] s_valid = 2'b00;
   logic [1:0] s_last = 2'b00;
   logic [1:0] s_ready;
   logic [7:0] tx_data;
   logic       tx_en, tx_er, busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gmii_tx_arbiter #(.IFG_BYTES(IFG), .PRE_BYTES(PRE)) dut (
      .clk(clk), .rst_n(rst_n), .byte_stb(byte_stb), .req(req), .grant(grant),
      .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er), .busy(busy)
   );

   typedef struct {
      logic [9:0] tx;   // {en, er, data} after the strobe edge
      logic [1:0] gnt;  // grant after the strobe edge
      logic [1:0] rdy;  // s_ready during the strobe cycle
      logic       bsy;  // busy after the strobe edge
   } slot_t;

   slot_t      exp_q[$];
   logic [7:0] pay[2][300];
   int         plen[2] = '{0, 0};
   int         puf[2] = '{-1, -1};
   int         pidx[2] = '{0, 0};
   int         favour = 0;
   int         ready_cnt, ready_exp, seg = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s got %h want %h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic en, input logic er, input logic [7:0] d,
                       input logic [1:0] g, input logic [1:0] r, input logic b);
      slot_t s;
      s.tx = {en, er, d}; s.gnt = g; s.rdy = r; s.bsy = b;
      exp_q.push_back(s);
   endtask

   // Expected slots of one whole frame from the granting strobe to the end of its gap.
   task automatic add_frame(input int w);
      logic [1:0] oh;
      oh = (w == 1) ? 2'b10 : 2'b01;
      for (int i = 0; i < PRE; i++) push(1'b1, 1'b0, 8'h55, oh, 2'b00, 1'b1);
      push(1'b1, 1'b0, 8'hD5, oh, 2'b00, 1'b1);
      for (int k = 0; k < plen[w]; k++) begin
         if (k == puf[w]) begin
            push(1'b1, 1'b1, 8'h00, 2'b00, 2'b00, 1'b1);
            break;
         end
         push(1'b1, 1'b0, pay[w][k], (k == plen[w] - 1) ? 2'b00 : oh, oh, 1'b1);
         ready_exp++;
      end
`ifdef GMII_TX_PAD_EN
      if (puf[w] < 0) for (int k = plen[w]; k < 60; k++) push(1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1);
`endif
      for (int i = 0; i < IFG; i++) push(1'b0, 1'b0, 8'h00, 2'b00, 2'b00, i != IFG - 1);
   endtask

   task automatic new_frame(input int w, input int len, input int uf);
      plen[w] = len; puf[w] = uf; pidx[w] = 0;
      for (int k = 0; k < len; k++) pay[w][k] = 8'($urandom);
      req[w] = 1'b1;
   endtask

   task automatic slot_step(input int n, input int div);
      slot_t      e;
      logic [1:0] rdy;
      e = exp_q[n];
      s_data0    = (pidx[0] < plen[0]) ? pay[0][pidx[0]] : 8'h00;
      s_data1    = (pidx[1] < plen[1]) ? pay[1][pidx[1]] : 8'h00;
      for (int i = 0; i < 2; i++) begin
         s_valid[i] = (pidx[i] < plen[i]) && (pidx[i] != puf[i]);
         s_last[i]  = (pidx[i] == plen[i] - 1);
      end
      byte_stb = 1'b1;
      #1;
      rdy = s_ready;
      check($sformatf("seg%0d slot%0d ready", seg, n), 16'(rdy), 16'(e.rdy));
      @(posedge clk); #1;
      byte_stb = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (rdy[i]) begin pidx[i]++; ready_cnt++; end
         if (grant[i]) req[i] = 1'b0;
      end
      check($sformatf("seg%0d slot%0d tx", seg, n), 16'({tx_en, tx_er, tx_data}), 16'(e.tx));
      check($sformatf("seg%0d slot%0d grant", seg, n), 16'(grant), 16'(e.gnt));
      check($sformatf("seg%0d slot%0d busy", seg, n), 16'(busy), 16'(e.bsy));
      for (int c = 1; c < div; c++) begin
         @(posedge clk); #1;
         check($sformatf("seg%0d slot%0d hold", seg, n), 16'({tx_en, tx_er, tx_data}), 16'(e.tx));
         check($sformatf("seg%0d slot%0d noready", seg, n), 16'(s_ready), 16'h0);
      end
   endtask

   // Tie goes to the requester not granted last; the frames then run back to back.
   task automatic run_segment(input bit f0, input bit f1, input int idle_after, input int div);
      int first;
      seg++;
      exp_q.delete(); ready_exp = 0; ready_cnt = 0;
      if (f0 && f1) begin
         first = favour;
         add_frame(first);
         add_frame(1 - first);
      end else if (f0) begin
         add_frame(0); favour = 1;
      end else if (f1) begin
         add_frame(1); favour = 0;
      end
      for (int i = 0; i < idle_after; i++) push(1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
      for (int n = 0; n < exp_q.size(); n++) slot_step(n, div);
      check($sformatf("seg%0d ready_count", seg), 16'(ready_cnt), 16'(ready_exp));
   endtask

   initial begin
      int w, len, uf;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset tx", 16'({tx_en, tx_er, tx_data}), 16'h0);
      check("reset grant", 16'(grant), 16'h0);
      check("reset busy", 16'(busy), 16'h0);
      check("reset ready", 16'(s_ready), 16'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      new_frame(0, 10, -1);          run_segment(1'b1, 1'b0, 3, 2);
      new_frame(0, 8, -1);
      new_frame(1, 5, -1);           run_segment(1'b1, 1'b1, 3, 1);
      new_frame(1, 12, 4);           run_segment(1'b0, 1'b1, 2, 1);
      new_frame(0, 20, -1);          run_segment(1'b1, 1'b0, 2, 3);
      new_frame(1, 300, -1);         run_segment(1'b0, 1'b1, 2, 1);

      for (int r = 0; r < 8; r++) begin
         w = $urandom_range(0, 2);
         for (int i = 0; i < 2; i++) begin
            if (w == i || w == 2) begin
               len = $urandom_range(1, 70);
               uf  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
               new_frame(i, len, uf);
            end
         end
         run_segment(w != 1, w != 0, 2, $urandom_range(1, 3));
      end

      // Abort during the third preamble byte, then restart with no gap.
      seg++;
      exp_q.delete();
      new_frame(0, 10, -1);
      add_frame(0);
      for (int n = 0; n < 3; n++) slot_step(n, 1);
      #3 rst_n = 1'b0;
      #1;
      check("abort tx", 16'({tx_en, tx_er, tx_data}), 16'h0);
      check("abort grant", 16'(grant), 16'h0);
      check("abort busy", 16'(busy), 16'h0);
      check("abort ready", 16'(s_ready), 16'h0);
      plen[0] = 0; pidx[0] = 0; req = 2'b00; favour = 0;
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      new_frame(1, 6, -1);           run_segment(1'b0, 1'b1, 2, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
